// File: rtl/anim_sequencer.sv
// Sprite animation sequencer: steps a sprite frame index, bounces a sprite
// horizontally between X_MIN and X_MAX and toggles a rainbow phase once
// every HOLD_FRAMES video frames while running. Supports pause and single-step.
module anim_sequencer #(
    parameter int NUM_FRAMES  = 6,
    parameter int HOLD_FRAMES = 16,
    parameter int X_MIN       = 64,
    parameter int X_MAX       = 368,
    parameter int X_STEP      = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_start,
    input  logic       enable,
    input  logic       step,
    output logic [2:0] anim_frame,
    output logic [9:0] sprite_left,
    output logic       rainbow_phase,
    output logic       running,
    output logic       update
);

    localparam int HOLD_W = (HOLD_FRAMES > 2) ? $clog2(HOLD_FRAMES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              pend_q, pend_d;
    logic              advance_s;

    logic [2:0]  frame_q, frame_d;
    logic [9:0]  left_q, left_d;
    logic        phase_q, phase_d;
    logic        dir_right_q, dir_right_d;
    logic        running_q, update_q;
    logic [10:0] sum_right_s;

    // Control FSM: state transitions, hold counter, step latch and advance decision
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        pend_d    = pend_q;
        advance_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (frame_start) begin
                    if (hold_q == HOLD_W'(HOLD_FRAMES - 1)) begin
                        advance_s = 1'b1;
                        hold_d    = '0;
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end else begin
                    hold_d = hold_q;
                end
                // An advance on the falling-enable cycle still happens above.
                if (!enable) begin
                    state_d = ST_PAUSED;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_PAUSED: begin
                if (enable) begin
                    // Resuming drops any pending single step without advancing.
                    state_d = ST_RUN;
                    pend_d  = 1'b0;
                end else if (frame_start && (pend_q || step)) begin
                    advance_s = 1'b1;
                    pend_d    = 1'b0;
                    hold_d    = '0;
                end else if (step) begin
                    pend_d = 1'b1;
                end else begin
                    pend_d = pend_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Advance datapath: frame index wrap, phase toggle, bouncing sprite position
    always_comb begin
        frame_d     = frame_q;
        left_d      = left_q;
        phase_d     = phase_q;
        dir_right_d = dir_right_q;
        sum_right_s = {1'b0, left_q} + 11'(X_STEP);
        if (advance_s) begin
            if (frame_q == 3'(NUM_FRAMES - 1)) begin
                frame_d = 3'd0;
            end else begin
                frame_d = frame_q + 3'd1;
            end
            phase_d = ~phase_q;
            if (dir_right_q) begin
                if (sum_right_s >= 11'(X_MAX)) begin
                    left_d      = 10'(X_MAX);
                    dir_right_d = 1'b0;
                end else begin
                    left_d = sum_right_s[9:0];
                end
            end else begin
                // left - step <= X_MIN, rearranged so nothing underflows
                if ({1'b0, left_q} <= (11'(X_MIN) + 11'(X_STEP))) begin
                    left_d      = 10'(X_MIN);
                    dir_right_d = 1'b1;
                end else begin
                    left_d = left_q - 10'(X_STEP);
                end
            end
        end else begin
            frame_d = frame_q;
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            hold_q      <= '0;
            pend_q      <= 1'b0;
            frame_q     <= 3'd0;
            left_q      <= 10'(X_MIN);
            phase_q     <= 1'b0;
            dir_right_q <= 1'b1;
            running_q   <= 1'b0;
            update_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            pend_q      <= pend_d;
            frame_q     <= frame_d;
            left_q      <= left_d;
            phase_q     <= phase_d;
            dir_right_q <= dir_right_d;
            running_q   <= (state_d == ST_RUN);
            update_q    <= advance_s;
        end
    end

    assign anim_frame    = frame_q;
    assign sprite_left   = left_q;
    assign rainbow_phase = phase_q;
    assign running       = running_q;
    assign update        = update_q;

endmodule

// File: tb/tb_anim_sequencer.sv
// Directed bench for anim_sequencer with HOLD_FRAMES=4 and a narrow
// 64..100 sprite track so both clamps are reached quickly.
module tb_anim_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_start = 1'b0;
    logic       enable = 1'b0;
    logic       step = 1'b0;
    logic [2:0] anim_frame;
    logic [9:0] sprite_left;
    logic       rainbow_phase;
    logic       running;
    logic       update;

    int checks = 0;
    int failures = 0;

    anim_sequencer #(
        .NUM_FRAMES (6),
        .HOLD_FRAMES(4),
        .X_MIN      (64),
        .X_MAX      (100),
        .X_STEP     (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_start  (frame_start),
        .enable       (enable),
        .step         (step),
        .anim_frame   (anim_frame),
        .sprite_left  (sprite_left),
        .rainbow_phase(rainbow_phase),
        .running      (running),
        .update       (update)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One frame_start pulse; upd is the update output in the following cycle.
    task automatic fs_pulse(output logic upd);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        upd = update;
        tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        frame_start = 1'b0;
        step = 1'b0;
        enable = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (anim_frame !== 3'd0 || sprite_left !== 10'd64 || rainbow_phase !== 1'b0 ||
            running !== 1'b0 || update !== 1'b0) begin
            failures++;
            $display("FAIL reset_values got frame=%0d left=%0d phase=%0b run=%0b upd=%0b exp 0/64/0/0/0",
                     anim_frame, sprite_left, rainbow_phase, running, update);
        end
    endtask

    task automatic test_idle();
        int ups;
        logic u;
        ups = 0;
        for (int i = 0; i < 10; i++) begin
            fs_pulse(u);
            if (u === 1'b1) ups++;
        end
        checks++;
        if (ups !== 0) begin
            failures++;
            $display("FAIL idle_updates got=%0d exp=0", ups);
        end
        checks++;
        if (running !== 1'b0 || anim_frame !== 3'd0 || sprite_left !== 10'd64) begin
            failures++;
            $display("FAIL idle_outputs got run=%0b frame=%0d left=%0d exp 0/0/64",
                     running, anim_frame, sprite_left);
        end
    endtask

    task automatic test_first_advance();
        int ups;
        logic u;
        do_reset();
        enable = 1'b1;
        tick();
        checks++;
        if (running !== 1'b1) begin
            failures++;
            $display("FAIL run_entry got=%0b exp=1", running);
        end
        ups = 0;
        for (int i = 0; i < 3; i++) begin
            fs_pulse(u);
            if (u === 1'b1) ups++;
        end
        checks++;
        if (ups !== 0) begin
            failures++;
            $display("FAIL early_update got=%0d exp=0", ups);
        end
        fs_pulse(u);
        checks++;
        if (u !== 1'b1 || anim_frame !== 3'd1 || sprite_left !== 10'd72 || rainbow_phase !== 1'b1) begin
            failures++;
            $display("FAIL first_advance got upd=%0b frame=%0d left=%0d phase=%0b exp 1/1/72/1",
                     u, anim_frame, sprite_left, rainbow_phase);
        end
        checks++;
        if (update !== 1'b0) begin
            failures++;
            $display("FAIL update_width got=%0b exp=0", update);
        end
    endtask

    task automatic test_wrap_clamp();
        int exp_frame [11] = '{1, 2, 3, 4, 5, 0, 1, 2, 3, 4, 5};
        int exp_left  [11] = '{72, 80, 88, 96, 100, 92, 84, 76, 68, 64, 72};
        int n;
        logic u;
        do_reset();
        enable = 1'b1;
        tick();
        n = 0;
        for (int i = 0; i < 44; i++) begin
            fs_pulse(u);
            if (u === 1'b1) begin
                if (n < 11) begin
                    checks++;
                    if (anim_frame !== 3'(exp_frame[n]) || sprite_left !== 10'(exp_left[n]) ||
                        rainbow_phase !== ((n % 2) == 0)) begin
                        failures++;
                        $display("FAIL advance_%0d got frame=%0d left=%0d phase=%0b exp %0d/%0d/%0b",
                                 n, anim_frame, sprite_left, rainbow_phase,
                                 exp_frame[n], exp_left[n], ((n % 2) == 0));
                    end
                end
                n++;
            end
            if (i == 35) begin
                checks++;
                if (n !== 9) begin
                    failures++;
                    $display("FAIL updates_after_36 got=%0d exp=9", n);
                end
            end
        end
        checks++;
        if (n !== 11) begin
            failures++;
            $display("FAIL updates_after_44 got=%0d exp=11", n);
        end
    endtask

    task automatic test_step();
        int ups;
        logic u;
        do_reset();
        enable = 1'b1;
        tick();
        fs_pulse(u);
        fs_pulse(u);
        enable = 1'b0;
        tick();
        checks++;
        if (running !== 1'b0) begin
            failures++;
            $display("FAIL pause_running got=%0b exp=0", running);
        end
        ups = 0;
        for (int i = 0; i < 3; i++) begin
            step = 1'b1;
            tick();
            step = 1'b0;
            if (update === 1'b1) ups++;
            tick();
        end
        fs_pulse(u);
        checks++;
        if (ups !== 0 || u !== 1'b1 || anim_frame !== 3'd1 || sprite_left !== 10'd72) begin
            failures++;
            $display("FAIL single_step got ups=%0d upd=%0b frame=%0d left=%0d exp 0/1/1/72",
                     ups, u, anim_frame, sprite_left);
        end
        ups = 0;
        for (int i = 0; i < 3; i++) begin
            fs_pulse(u);
            if (u === 1'b1) ups++;
        end
        checks++;
        if (ups !== 0 || anim_frame !== 3'd1) begin
            failures++;
            $display("FAIL paused_no_step got ups=%0d frame=%0d exp 0/1", ups, anim_frame);
        end
        // Hold counter was cleared by the step: four more frames needed.
        enable = 1'b1;
        tick();
        ups = 0;
        for (int i = 0; i < 3; i++) begin
            fs_pulse(u);
            if (u === 1'b1) ups++;
        end
        fs_pulse(u);
        checks++;
        if (ups !== 0 || u !== 1'b1 || anim_frame !== 3'd2 || sprite_left !== 10'd80) begin
            failures++;
            $display("FAIL hold_cleared got ups=%0d upd=%0b frame=%0d left=%0d exp 0/1/2/80",
                     ups, u, anim_frame, sprite_left);
        end
    endtask

    task automatic test_resume_and_same_cycle_step();
        logic u;
        // Pending step is dropped on resume.
        enable = 1'b0;
        tick();
        step = 1'b1;
        tick();
        step = 1'b0;
        enable = 1'b1;
        tick();
        enable = 1'b0;
        tick();
        fs_pulse(u);
        checks++;
        if (u !== 1'b0 || anim_frame !== 3'd2) begin
            failures++;
            $display("FAIL resume_clears_step got upd=%0b frame=%0d exp 0/2", u, anim_frame);
        end
        // Step while running is ignored.
        enable = 1'b1;
        tick();
        step = 1'b1;
        tick();
        step = 1'b0;
        enable = 1'b0;
        tick();
        fs_pulse(u);
        checks++;
        if (u !== 1'b0 || anim_frame !== 3'd2) begin
            failures++;
            $display("FAIL run_step_ignored got upd=%0b frame=%0d exp 0/2", u, anim_frame);
        end
        // Step together with frame_start while paused advances at once.
        frame_start = 1'b1;
        step = 1'b1;
        tick();
        frame_start = 1'b0;
        step = 1'b0;
        checks++;
        if (update !== 1'b1 || anim_frame !== 3'd3 || sprite_left !== 10'd88) begin
            failures++;
            $display("FAIL same_cycle_step got upd=%0b frame=%0d left=%0d exp 1/3/88",
                     update, anim_frame, sprite_left);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic u;
        do_reset();
        enable = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) fs_pulse(u);
        enable = 1'b0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        checks++;
        if (update !== 1'b1 || running !== 1'b0 || anim_frame !== 3'd1) begin
            failures++;
            $display("FAIL advance_on_disable got upd=%0b run=%0b frame=%0d exp 1/0/1",
                     update, running, anim_frame);
        end
        tick();
        checks++;
        if (update !== 1'b0) begin
            failures++;
            $display("FAIL advance_on_disable_pulse got=%0b exp=0", update);
        end
    endtask

    task automatic test_reset_mid();
        logic u;
        do_reset();
        enable = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) fs_pulse(u);
        frame_start = 1'b1;
        rst_n = 1'b0;
        tick();
        checks++;
        if (update !== 1'b0 || anim_frame !== 3'd0 || sprite_left !== 10'd64 ||
            rainbow_phase !== 1'b0 || running !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid got upd=%0b frame=%0d left=%0d phase=%0b run=%0b exp 0/0/64/0/0",
                     update, anim_frame, sprite_left, rainbow_phase, running);
        end
        frame_start = 1'b0;
        rst_n = 1'b1;
        tick();
        checks++;
        if (update !== 1'b0 || anim_frame !== 3'd0) begin
            failures++;
            $display("FAIL reset_mid_after got upd=%0b frame=%0d exp 0/0", update, anim_frame);
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_first_advance();
        test_wrap_clamp();
        test_step();
        test_resume_and_same_cycle_step();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/anim_sequencer.md
ANIM_SEQUENCER -- requirements
Module: anim_sequencer

Interface
REQ-001 SHALL have parameter NUM_FRAMES, default 6, number of sprite animation frames.
REQ-002 SHALL have parameter HOLD_FRAMES, default 16, VGA frames per animation step (>=2).
REQ-003 SHALL have parameter X_MIN, default 64, leftmost sprite position.
REQ-004 SHALL have parameter X_MAX, default 368, rightmost sprite position.
REQ-005 SHALL have parameter X_STEP, default 8, sprite move per animation step.
REQ-006 SHALL have ports: clk  in  1  clock; rst_n  in  1  reset, synchronous, active-low.
REQ-007 SHALL have port frame_start  in  1  one-cycle pulse, once per VGA frame at start of vertical blank.
REQ-008 SHALL have port enable  in  1  level; 1 = animate, 0 = pause.
REQ-009 SHALL have port step  in  1  one-cycle pulse; single-step request while paused.
REQ-010 SHALL have port anim_frame  out  3  current sprite frame index, 0..NUM_FRAMES-1.
REQ-011 SHALL have port sprite_left  out  10  current sprite left edge, X_MIN..X_MAX.
REQ-012 SHALL have port rainbow_phase  out  1  rainbow trail phase select.
REQ-013 SHALL have port running  out  1  high while in RUN state.
REQ-014 SHALL have port update  out  1  one-cycle pulse in the cycle new output values first appear.

Function
REQ-015 SHALL implement states IDLE, RUN, PAUSED; running = (state == RUN), registered.
REQ-016 IDLE -> RUN on first cycle enable=1; RUN -> PAUSED when enable=0; PAUSED -> RUN when enable=1; no return to IDLE except reset.
REQ-017 SHALL keep a hold counter 0..HOLD_FRAMES-1, incremented only on frame_start sampled in RUN; frozen in IDLE and PAUSED.
REQ-018 In RUN, frame_start with hold counter == HOLD_FRAMES-1 SHALL perform an advance and wrap counter to 0.
REQ-019 Advance: anim_frame += 1, wrapping NUM_FRAMES-1 -> 0; rainbow_phase toggles; sprite_left moves X_STEP in current direction.
REQ-020 Moving right: if sprite_left + X_STEP >= X_MAX, sprite_left = X_MAX and direction flips to left; symmetric clamp at X_MIN flipping to right.
REQ-021 Position arithmetic SHALL use 11-bit intermediates; no wrap-around of sprite_left.
REQ-022 All outputs SHALL change only on the clock edge that samples frame_start=1 (latency 1 cycle); update=1 for exactly that following cycle, 0 otherwise.
REQ-023 step sampled in PAUSED SHALL set step_pending; step in IDLE or RUN ignored; repeated steps before frame_start collapse to one.
REQ-024 In PAUSED, frame_start with step_pending=1 (or step=1 same cycle) SHALL advance, clear step_pending, reset hold counter to 0.
REQ-025 Leaving PAUSED to RUN SHALL clear step_pending without advancing.
REQ-026 frame_start in IDLE, or in PAUSED without pending step, SHALL cause no output change and no update pulse.
REQ-027 enable falling in the same cycle as an advancing frame_start: advance SHALL occur, state becomes PAUSED.

Reset
REQ-028 rst_n=0 at a clock edge SHALL force: state IDLE, anim_frame 0, sprite_left X_MIN, rainbow_phase 0, running 0, update 0, direction right, hold counter 0, step_pending 0.
REQ-029 Reset mid-operation SHALL override any concurrent frame_start, step or enable; no update pulse in the reset cycle or the cycle after.

Verification
REQ-030 HOLD_FRAMES=4, enable=1, 4 frame_starts -> one update pulse after the 4th; anim_frame 1, sprite_left 72, rainbow_phase 1.
REQ-031 NUM_FRAMES=6, 36 frame_starts in RUN -> anim_frame sequence 1..5,0,1,..., wraps to 0 after 24th; 9 update pulses total.
REQ-032 X_MIN=64, X_MAX=100, X_STEP=8 -> sprite_left 72,80,88,96,100,92,...; clamp at 100 then direction left.
REQ-033 enable=0 after 2 frame_starts, 3 step pulses then 1 frame_start -> exactly one advance, hold counter 0; further frame_starts no change.
REQ-034 rst_n=0 asserted the cycle frame_start would cause an advance -> outputs at reset values, update stays 0, running 0.
REQ-035 enable=0 from reset, 10 frame_starts -> state IDLE, no updates, outputs unchanged.
